// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has priority,
// long-latency unit (B) is protected from starvation and tracked in a scoreboard.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        a_valid,
    input  logic [4:0]  a_sel,
    input  logic [31:0] a_dat,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_sel,
    input  logic [31:0] b_dat,
    output logic        b_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_sel,
    input  logic [4:0]  chk_sel1,
    input  logic [4:0]  chk_sel2,
    output logic        chk_busy1,
    output logic        chk_busy2,
    output logic        WEN,
    output logic [4:0]  wsel,
    output logic [31:0] wdat
);

    typedef enum logic {NORMAL, FORCE_B} mode_t;

    mode_t            mode;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      pending;
    logic [31:0]      set_mask;
    logic [31:0]      clr_mask;
    logic             grant_a;
    logic             grant_b;
    logic             b_starved;

    always_comb begin
        a_ready = (mode == NORMAL)  ? 1'b1 : !b_valid;
        b_ready = (mode == FORCE_B) ? 1'b1 : !a_valid;
        grant_a = a_valid && a_ready;
        grant_b = b_valid && b_ready;
    end

    always_comb begin
        wsel = 5'd0;
        wdat = 32'd0;
        if (grant_a) begin
            wsel = a_sel;
            wdat = a_dat;
        end else if (grant_b) begin
            wsel = b_sel;
            wdat = b_dat;
        end
    end

    // Writes to x0 are acknowledged but never reach the register file.
    assign WEN = nRST && (grant_a || grant_b) && (wsel != 5'd0);

    assign b_starved = b_valid && !b_ready;
    assign cnt_inc   = (&starve_cnt) ? starve_cnt : starve_cnt + 1'b1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mode       <= NORMAL;
            starve_cnt <= '0;
        end else if (b_starved) begin
            starve_cnt <= cnt_inc;
            if (cnt_inc == CNT_W'(STARVE_LIMIT))
                mode <= FORCE_B;
        end else begin
            starve_cnt <= '0;
            mode       <= NORMAL;
        end
    end

    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (iss_valid && iss_sel != 5'd0)
            set_mask = 32'd1 << iss_sel;
        if (grant_b)
            clr_mask = 32'd1 << b_sel;
    end

    // A newly issued op to the same register outlives the completing one.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            pending <= 32'd0;
        else
            pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_comb begin
        chk_busy1 = pending[chk_sel1] && !(grant_b && b_sel == chk_sel1);
        chk_busy2 = pending[chk_sel2] && !(grant_b && b_sel == chk_sel2);
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: priority, starvation, scoreboard, reset.
module tb_rf_wb_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        a_valid, b_valid, iss_valid;
    logic [4:0]  a_sel, b_sel, iss_sel, chk_sel1, chk_sel2;
    logic [31:0] a_dat, b_dat;
    logic        a_ready, b_ready, chk_busy1, chk_busy2, WEN;
    logic [4:0]  wsel;
    logic [31:0] wdat;

    int vectors = 0;
    int miscompares = 0;

    rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .CLK(CLK), .nRST(nRST),
        .a_valid(a_valid), .a_sel(a_sel), .a_dat(a_dat), .a_ready(a_ready),
        .b_valid(b_valid), .b_sel(b_sel), .b_dat(b_dat), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_sel(iss_sel),
        .chk_sel1(chk_sel1), .chk_sel2(chk_sel2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .WEN(WEN), .wsel(wsel), .wdat(wdat)
    );

    always #5 CLK = ~CLK;

    task automatic idle();
        a_valid = 0; a_sel = 0; a_dat = 0;
        b_valid = 0; b_sel = 0; b_dat = 0;
        iss_valid = 0; iss_sel = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        nRST = 0; idle(); chk_sel1 = 12; chk_sel2 = 0;
        #2;
        vectors++; if (WEN !== 1'b0) begin miscompares++; $display("FAIL rst_wen got %0b want 0", WEN); end
        vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL rst_a_ready got %0b want 1", a_ready); end
        vectors++; if (b_ready !== 1'b1) begin miscompares++; $display("FAIL rst_b_ready got %0b want 1", b_ready); end
        vectors++; if (chk_busy1 !== 1'b0) begin miscompares++; $display("FAIL rst_busy1 got %0b want 0", chk_busy1); end
        a_valid = 1; a_sel = 3;
        #1;
        vectors++; if (b_ready !== 1'b0) begin miscompares++; $display("FAIL rst_b_ready_av got %0b want 0", b_ready); end
        vectors++; if (WEN !== 1'b0) begin miscompares++; $display("FAIL rst_wen_av got %0b want 0", WEN); end
        idle();
        @(negedge CLK);
        nRST = 1;
        tick();
    endtask

    task automatic test_priority();
        a_valid = 1; a_sel = 5; a_dat = 32'hDEADBEEF;
        b_valid = 1; b_sel = 9; b_dat = 32'h12345678;
        #1;
        vectors++; if (WEN !== 1'b1) begin miscompares++; $display("FAIL prio_wen got %0b want 1", WEN); end
        vectors++; if (wsel !== 5'd5) begin miscompares++; $display("FAIL prio_wsel got %0d want 5", wsel); end
        vectors++; if (wdat !== 32'hDEADBEEF) begin miscompares++; $display("FAIL prio_wdat got %h want deadbeef", wdat); end
        vectors++; if (b_ready !== 1'b0) begin miscompares++; $display("FAIL prio_b_ready got %0b want 0", b_ready); end
        tick();
        a_valid = 0;
        #1;
        vectors++; if (wsel !== 5'd9) begin miscompares++; $display("FAIL prio_b_wsel got %0d want 9", wsel); end
        vectors++; if (wdat !== 32'h12345678) begin miscompares++; $display("FAIL prio_b_wdat got %h want 12345678", wdat); end
        vectors++; if (b_ready !== 1'b1) begin miscompares++; $display("FAIL prio_b_ready2 got %0b want 1", b_ready); end
        vectors++; if (WEN !== 1'b1) begin miscompares++; $display("FAIL prio_b_wen got %0b want 1", WEN); end
        tick();
        idle(); tick();
    endtask

    task automatic test_starve();
        logic exp_b;
        a_valid = 1; a_sel = 3; a_dat = 32'h33;
        b_valid = 1; b_sel = 4; b_dat = 32'h44;
        for (int c = 1; c <= 6; c++) begin
            exp_b = (c == 5);
            #1;
            vectors++; if (b_ready !== exp_b) begin miscompares++; $display("FAIL starve_b_ready c%0d got %0b want %0b", c, b_ready, exp_b); end
            vectors++; if (a_ready !== !exp_b) begin miscompares++; $display("FAIL starve_a_ready c%0d got %0b want %0b", c, a_ready, !exp_b); end
            vectors++; if (wsel !== (exp_b ? 5'd4 : 5'd3)) begin miscompares++; $display("FAIL starve_wsel c%0d got %0d want %0d", c, wsel, exp_b ? 4 : 3); end
            tick();
        end
        idle(); tick();
    endtask

    task automatic test_scoreboard();
        iss_valid = 1; iss_sel = 12;
        tick();
        iss_valid = 0; chk_sel1 = 12; chk_sel2 = 13;
        #1;
        vectors++; if (chk_busy1 !== 1'b1) begin miscompares++; $display("FAIL sb_busy1 got %0b want 1", chk_busy1); end
        vectors++; if (chk_busy2 !== 1'b0) begin miscompares++; $display("FAIL sb_busy2 got %0b want 0", chk_busy2); end
        tick();
        b_valid = 1; b_sel = 12; b_dat = 32'hCAFE;
        #1;
        vectors++; if (chk_busy1 !== 1'b0) begin miscompares++; $display("FAIL sb_bypass got %0b want 0", chk_busy1); end
        vectors++; if (WEN !== 1'b1) begin miscompares++; $display("FAIL sb_wen got %0b want 1", WEN); end
        tick();
        idle(); chk_sel2 = 0;
        #1;
        vectors++; if (chk_busy1 !== 1'b0) begin miscompares++; $display("FAIL sb_cleared got %0b want 0", chk_busy1); end
        vectors++; if (chk_busy2 !== 1'b0) begin miscompares++; $display("FAIL sb_sel0 got %0b want 0", chk_busy2); end
        tick();
    endtask

    task automatic test_set_wins();
        iss_valid = 1; iss_sel = 7; chk_sel1 = 7;
        tick();
        b_valid = 1; b_sel = 7; b_dat = 32'h77;
        #1;
        vectors++; if (chk_busy1 !== 1'b0) begin miscompares++; $display("FAIL sw_bypass got %0b want 0", chk_busy1); end
        tick();
        idle();
        #1;
        vectors++; if (chk_busy1 !== 1'b1) begin miscompares++; $display("FAIL sw_still_set got %0b want 1", chk_busy1); end
        b_valid = 1; b_sel = 7;
        tick();
        idle();
        #1;
        vectors++; if (chk_busy1 !== 1'b0) begin miscompares++; $display("FAIL sw_cleared got %0b want 0", chk_busy1); end
        tick();
    endtask

    task automatic test_zero_write();
        a_valid = 1; a_sel = 0; a_dat = 32'hFFFF;
        #1;
        vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL zero_a_ready got %0b want 1", a_ready); end
        vectors++; if (WEN !== 1'b0) begin miscompares++; $display("FAIL zero_a_wen got %0b want 0", WEN); end
        tick();
        idle(); b_valid = 1; b_sel = 0; b_dat = 32'h1;
        iss_valid = 1; iss_sel = 0; chk_sel1 = 0;
        #1;
        vectors++; if (b_ready !== 1'b1) begin miscompares++; $display("FAIL zero_b_ready got %0b want 1", b_ready); end
        vectors++; if (WEN !== 1'b0) begin miscompares++; $display("FAIL zero_b_wen got %0b want 0", WEN); end
        tick();
        idle();
        #1;
        vectors++; if (chk_busy1 !== 1'b0) begin miscompares++; $display("FAIL zero_pending got %0b want 0", chk_busy1); end
        tick();
    endtask

    task automatic test_a_no_pending();
        iss_valid = 1; iss_sel = 20; chk_sel2 = 20;
        tick();
        idle(); a_valid = 1; a_sel = 20; a_dat = 32'hA;
        #1;
        vectors++; if (chk_busy2 !== 1'b1) begin miscompares++; $display("FAIL apend_busy got %0b want 1", chk_busy2); end
        tick();
        idle();
        #1;
        vectors++; if (chk_busy2 !== 1'b1) begin miscompares++; $display("FAIL apend_after got %0b want 1", chk_busy2); end
        b_valid = 1; b_sel = 20;
        tick();
        idle(); chk_sel2 = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic exp_b;
        iss_valid = 1; iss_sel = 12; chk_sel1 = 12;
        tick();
        idle();
        a_valid = 1; a_sel = 3; b_valid = 1; b_sel = 4;
        for (int c = 1; c <= 4; c++) tick();
        #1;
        vectors++; if (a_ready !== 1'b0) begin miscompares++; $display("FAIL mid_force_a got %0b want 0", a_ready); end
        vectors++; if (chk_busy1 !== 1'b1) begin miscompares++; $display("FAIL mid_pend got %0b want 1", chk_busy1); end
        nRST = 0;
        #1;
        vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_a got %0b want 1", a_ready); end
        vectors++; if (b_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_b got %0b want 0", b_ready); end
        vectors++; if (WEN !== 1'b0) begin miscompares++; $display("FAIL mid_rst_wen got %0b want 0", WEN); end
        vectors++; if (chk_busy1 !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got %0b want 0", chk_busy1); end
        @(negedge CLK);
        nRST = 1;
        for (int c = 1; c <= 5; c++) begin
            exp_b = (c == 5);
            #1;
            vectors++; if (b_ready !== exp_b) begin miscompares++; $display("FAIL mid_cnt c%0d got %0b want %0b", c, b_ready, exp_b); end
            tick();
        end
        idle();
        #1;
        vectors++; if (chk_busy1 !== 1'b0) begin miscompares++; $display("FAIL mid_pend_after got %0b want 0", chk_busy1); end
        tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_starve();
        test_scoreboard();
        test_set_wins();
        test_zero_write();
        test_a_no_pending();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
